// File: rtl/ifetch_unit.sv
// ifetch_unit: PC register plus 2-entry fetch buffer feeding decode.
// Fetches one word per cycle from a windowed, combinational instruction memory.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00003000,
  parameter logic [31:0] IM_BASE  = 32'h00003000,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  localparam logic [31:0] IM_LAST =
    IM_BASE + 32'(IM_WORDS * 4) - 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_t;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        fault_q;
  logic        fault_d;
  fq_t         e0_q;
  fq_t         e0_d;
  fq_t         e1_q;
  fq_t         e1_d;
  logic [1:0]  cnt_q;
  logic [1:0]  cnt_d;

  logic [31:0] tgt;
  logic        pc_ok;
  logic        tgt_ok;
  logic        full;
  logic        pop;
  logic        push;
  fq_t         fetched;

  assign tgt     = redirect_pc & 32'hFFFF_FFFC;
  assign pc_ok   = (pc_q >= IM_BASE) && (pc_q <= IM_LAST);
  assign tgt_ok  = (tgt >= IM_BASE) && (tgt <= IM_LAST);
  assign full    = (cnt_q == 2'd2);
  assign pop     = out_valid && out_ready;
  assign push    = !redirect_valid && !fault_q && pc_ok
                   && (!full || pop);
  assign fetched = '{pc: pc_q, instr: imem_rdata};

  assign imem_addr   = pc_q;
  assign out_valid   = (cnt_q != 2'd0);
  assign out_instr   = e0_q.instr;
  assign out_pc      = e0_q.pc;
  assign fetch_fault = fault_q;

  // Next PC and sticky fault: redirect wins, else step on push.
  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    if (redirect_valid) begin
      pc_d = tgt;
      if (tgt_ok) fault_d = 1'b0;
    end else begin
      if (push)   pc_d    = pc_q + 32'd4;
      if (!pc_ok) fault_d = 1'b1;
    end
  end

  // Buffer next state: e0 is the head, e1 the tail slot.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (redirect_valid) begin
      cnt_d = 2'd0;
    end else begin
      unique case (1'b1)
        push && pop: begin
          if (cnt_q == 2'd1) begin
            e0_d = fetched;
          end else begin
            e0_d = e1_q;
            e1_d = fetched;
          end
        end
        push && !pop: begin
          if (cnt_q == 2'd0) e0_d = fetched;
          else               e1_d = fetched;
          cnt_d = cnt_q + 2'd1;
        end
        !push && pop: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  // State registers; reset overrides redirect, fetch and pop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      cnt_q   <= 2'd0;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed + random stimulus, queue-based reference model,
// negedge monitor compares dequeued entries and architectural state.
module tb_ifetch_unit;

  localparam logic [31:0] BASE  = 32'h00003000;
  localparam int          WORDS = 1024;
  localparam logic [31:0] LAST  = BASE + 32'(WORDS * 4) - 32'd4;
  localparam logic [31:0] RPC   = 32'h00003000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_ready = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  ifetch_unit #(
    .RESET_PC(RPC),
    .IM_BASE (BASE),
    .IM_WORDS(WORDS)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .fetch_fault   (fetch_fault)
  );

  logic [31:0] mem [WORDS];

  function automatic bit inr(logic [31:0] a);
    return (a >= BASE) && (a <= LAST);
  endfunction

  function automatic logic [31:0] rd(logic [31:0] a);
    int idx;
    idx = int'((a - BASE) >> 2);
    return mem[idx];
  endfunction

  always_comb begin
    imem_rdata = 32'hDEADBEEF;
    if (inr(imem_addr)) imem_rdata = rd(imem_addr);
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] m_pc = RPC;
  bit          m_fault = 1'b0;
  int          occ0 = 0;
  bit          go = 1'b0;
  int          checks = 0;
  int          passes = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock of stimulus, then advance the reference model past the edge.
  task automatic cyc(bit rst, bit rv, logic [31:0] rpc, bit rdy);
    bit popd;
    reset_n        = !rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    occ0           = exp_q.size();
    @(posedge clk);
    #1;
    if (rst) begin
      m_pc    = RPC;
      m_fault = 1'b0;
      exp_q.delete();
    end else if (rv) begin
      exp_q.delete();
      m_pc = rpc & ~32'h3;
      if (inr(m_pc)) m_fault = 1'b0;
    end else begin
      popd = (occ0 > 0) && rdy;
      if (!m_fault && inr(m_pc) && (occ0 < 2 || popd)) begin
        exp_q.push_back('{pc: m_pc, instr: rd(m_pc)});
        m_pc = m_pc + 32'd4;
      end else if (!inr(m_pc)) begin
        m_fault = 1'b1;
      end
    end
  endtask

  // Monitor: mid-cycle compare of state and of every accepted entry.
  always @(negedge clk) begin
    ent_t e;
    if (go) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL dequeue: got pc %h required no entry", out_pc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_instr", out_instr, e.instr);
        end
      end
    end
  end

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] t;
    case ($urandom_range(0, 3))
      0: t = BASE + 32'($urandom_range(0, WORDS - 1) << 2)
             + 32'($urandom_range(0, 3));
      1: t = LAST - 32'd8 + 32'($urandom_range(0, 15));
      2: t = $urandom;
      default: t = 32'hFFFFFFFC;
    endcase
    return t;
  endfunction

  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    mem[3] = 32'h44;

    cyc(1, 0, 0, 0);
    go = 1'b1;
    cyc(1, 0, 0, 0);
    chk("rst out_pc", out_pc, 32'h0);
    chk("rst out_instr", out_instr, 32'h0);
    chk("rst out_valid", 32'(out_valid), 32'h0);
    chk("rst imem_addr", imem_addr, RPC);

    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);

    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    chk("stall pc", imem_addr, 32'h3008);
    chk("stall head", out_pc, 32'h3000);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 32'h3103, 1);
    chk("redir valid", 32'(out_valid), 32'h0);
    chk("redir addr", imem_addr, 32'h3100);
    cyc(0, 0, 0, 0);
    chk("redir head", out_pc, 32'h3100);

    cyc(0, 1, 32'h3FFC, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    chk("end fault", 32'(fetch_fault), 32'h1);
    chk("end pc", imem_addr, 32'h4000);
    cyc(0, 1, 32'h3000, 1);
    chk("clr fault", 32'(fetch_fault), 32'h0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

    cyc(0, 1, 32'h0, 1);
    cyc(0, 0, 0, 1);
    chk("low fault", 32'(fetch_fault), 32'h1);
    cyc(1, 0, 0, 1);
    chk("rst fault", 32'(fetch_fault), 32'h0);
    chk("rst addr", imem_addr, RPC);

    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 32'h3500, 1);
    chk("rst+redir valid", 32'(out_valid), 32'h0);
    chk("rst+redir addr", imem_addr, RPC);

    for (int i = 0; i < 4000; i++) begin
      bit rst;
      bit rv;
      rst = ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      cyc(rst, rv, rnd_tgt(), $urandom_range(0, 3) != 0);
    end

    go = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
